fpu_exception_pipe: RTL and testbench
=====================================

# fpu_exception_pipe

Pipelined IEEE-754 result finaliser for the Vector ALU FPU lanes. It sits between the add/sub/mul/div datapaths and the VGPR writeback. It selects the unit result by operation and classifies operands and result. It then overrides the result for invalid, divide-by-zero, overflow and flush-to-zero cases, and raises per-op exception flags plus sticky status flags. Compared with the single-stage finaliser it adds a BIT_WIDTH-generic 32/64 datapath, divide support, FTZ mode, a ready/valid 2-stage pipeline and a sticky flag register.

## Interface
- BIT_WIDTH, 32, operand width; 32 or 64 only.
- EXP_WIDTH, derived (8/11), exponent width.
- MAN_WIDTH, derived (23/52), stored mantissa width.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept an input beat this cycle.
- i_operation  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- i_inputA, i_inputB  in  BIT_WIDTH  original operands.
- i_add_out, i_sub_out, i_mul_out, i_div_out  in  BIT_WIDTH  unit results.
- i_add_inexact, i_sub_inexact, i_mul_inexact, i_div_inexact  in  1  unit rounding flags.
- i_ftz  in  1  flush subnormal results to signed zero; sampled with the beat.
- i_flag_clear  in  1  clear sticky flags.
- o_valid  out  1  output beat valid.
- i_ready  in  1  consumer accepts the output beat.
- o_output  out  BIT_WIDTH  final result.
- o_exception  out  5  [4] overflow, [3] underflow, [2] div-by-zero, [1] invalid, [0] inexact; qualified by o_valid.
- o_sticky  out  5  accumulated flags, same bit order.

## Operation
- Operand classes, with E = exponent field and M = mantissa field:
  - NaN: E all ones, M ≠ 0.
  - Inf: E all ones, M = 0.
  - Zero: E = 0, M = 0.
- Result R and inexact flag X are selected by i_operation.
- Flag and output rules, in priority order; the first match wins:
  1. Invalid: any NaN operand; ADD/SUB with both Inf and effective opposite signs (signA ^ signB ^ op[0] = 1); MUL Inf×Zero; DIV 0/0 or Inf/Inf. Output is canonical qNaN: sign 0, E all ones, M = {1, 0…}. Flags = 00010.
  2. Div-by-zero: DIV with finite non-zero A and Zero B. Output is Inf with sign A^B. Flags = 00100.
  3. Any Inf operand, not caught above: output R, flags 00000.
  4. Overflow: R.E all ones and X = 1. Output is Inf with sign R. Flags = 10001.
  5. Underflow: R.E = 0 and X = 1. Output is R, or signed zero if i_ftz. Flags = 01001.
  6. FTZ of exact subnormal: i_ftz, R.E = 0, R.M ≠ 0, X = 0. Output is signed zero. Flags = 01001.
  7. Otherwise: output R, flags {0000, X}.
- Sticky: on an output handshake (o_valid & i_ready), o_sticky |= o_exception.
- If i_flag_clear is high in the same cycle as a handshake, o_sticky takes only the new flags. If i_flag_clear is high without a handshake, o_sticky becomes 0.

## Timing
- Reset: all stage valids, o_valid, o_output, o_exception and o_sticky are 0 on the first clock edge with rst high. In-flight beats are discarded. o_ready is 1 in the cycle after rst deasserts.
- Pipeline: S1 registers operands, selected R/X, i_ftz and operand classes. S2 registers final o_output and o_exception.
- Latency: exactly 2 cycles from input handshake to o_valid with i_ready held high. Throughput is 1 beat per cycle.
- Advance rule: S2 loads when !S2.valid or i_ready. S1 loads when !S1.valid or S2 loads.
- o_ready = !S1.valid | S2 load. This is a combinational path from i_ready.
- Capacity: 2 beats. With i_ready low, o_ready drops after 2 accepted beats. No beat is lost or duplicated, and order is preserved.
- While o_valid & !i_ready: o_output and o_exception hold stable.
- i_valid while o_ready = 0: the beat is ignored; the source holds it.

## Test plan
- BIT_WIDTH=32, ADD 0x7F800000 + 0xFF800000 -> 2 cycles later o_output 0x7FC00000, o_exception 00010.
- DIV 0x3F800000 / 0x80000000 -> 0xFF800000, 00100. DIV 0x00000000 / 0x00000000 -> 0x7FC00000, 00010.
- MUL 0x7F000000 × 0x40000000, i_mul_out 0x7F800000, inexact 1 -> 0x7F800000, 10001.
- MUL out 0x80000001, inexact 1: i_ftz=1 -> 0x80000000, 01001. i_ftz=0 -> 0x80000001, 01001.
- Feed 4 back-to-back beats with i_ready low for 3 cycles -> o_ready low after the 2nd beat. All 4 outputs appear in order, held stable while stalled.
- Sticky: invalid, then overflow -> o_sticky 10011. Clear with a handshake carrying 00001 -> 00001. rst mid-stream -> o_valid 0, o_sticky 0 next cycle. Repeat the first scenario at BIT_WIDTH=64 -> 0x7FF8000000000000.

Source files
------------

// File: rtl/fpu_exception_pipe.sv
// Two-stage IEEE-754 result finaliser: selects the unit result, applies exception
// overrides (invalid, div-by-zero, overflow, underflow/FTZ) and accumulates sticky flags.
module fpu_exception_pipe #(
  parameter int unsigned BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_operation,
  input  logic [BIT_WIDTH-1:0] i_inputA,
  input  logic [BIT_WIDTH-1:0] i_inputB,
  input  logic [BIT_WIDTH-1:0] i_add_out,
  input  logic [BIT_WIDTH-1:0] i_sub_out,
  input  logic [BIT_WIDTH-1:0] i_mul_out,
  input  logic [BIT_WIDTH-1:0] i_div_out,
  input  logic                 i_add_inexact,
  input  logic                 i_sub_inexact,
  input  logic                 i_mul_inexact,
  input  logic                 i_div_inexact,
  input  logic                 i_ftz,
  input  logic                 i_flag_clear,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [BIT_WIDTH-1:0] o_output,
  output logic [4:0]           o_exception,
  output logic [4:0]           o_sticky
);

  localparam int unsigned EXP_WIDTH = (BIT_WIDTH == 64) ? 11 : 8;
  localparam int unsigned MAN_WIDTH = BIT_WIDTH - EXP_WIDTH - 1;

  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [BIT_WIDTH-1:0] QNAN =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};

  // Returns {nan, inf, zero}.
  function automatic logic [2:0] classify(input logic [BIT_WIDTH-1:0] v);
    logic e_ones, e_zero, m_zero;
    e_ones = &v[BIT_WIDTH-2 -: EXP_WIDTH];
    e_zero = ~|v[BIT_WIDTH-2 -: EXP_WIDTH];
    m_zero = ~|v[MAN_WIDTH-1:0];
    return {e_ones & ~m_zero, e_ones & m_zero, e_zero & m_zero};
  endfunction

  function automatic logic [BIT_WIDTH-1:0] inf_of(input logic sign);
    return {sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
  endfunction

  function automatic logic [BIT_WIDTH-1:0] zero_of(input logic sign);
    return {sign, {(BIT_WIDTH-1){1'b0}}};
  endfunction

  logic                 s1_valid;
  logic [1:0]           s1_op;
  logic                 s1_sign_a, s1_sign_b;
  logic [2:0]           s1_cls_a, s1_cls_b;
  logic [BIT_WIDTH-1:0] s1_r;
  logic                 s1_x;
  logic                 s1_ftz;

  logic                 s1_load, s2_load, out_fire;
  logic [BIT_WIDTH-1:0] sel_r;
  logic                 sel_x;
  logic [BIT_WIDTH-1:0] fin_out;
  logic [4:0]           fin_exc;

  assign s2_load  = !o_valid || i_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign o_ready  = s1_load;
  assign out_fire = o_valid && i_ready;

  // Unit result / inexact selection by operation.
  always_comb begin
    sel_r = i_add_out;
    sel_x = i_add_inexact;
    unique case (i_operation)
      2'b00: begin sel_r = i_add_out; sel_x = i_add_inexact; end
      2'b01: begin sel_r = i_sub_out; sel_x = i_sub_inexact; end
      2'b10: begin sel_r = i_mul_out; sel_x = i_mul_inexact; end
      default: begin sel_r = i_div_out; sel_x = i_div_inexact; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_sign_a <= 1'b0;
      s1_sign_b <= 1'b0;
      s1_cls_a  <= '0;
      s1_cls_b  <= '0;
      s1_r      <= '0;
      s1_x      <= 1'b0;
      s1_ftz    <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_op     <= i_operation;
        s1_sign_a <= i_inputA[BIT_WIDTH-1];
        s1_sign_b <= i_inputB[BIT_WIDTH-1];
        s1_cls_a  <= classify(i_inputA);
        s1_cls_b  <= classify(i_inputB);
        s1_r      <= sel_r;
        s1_x      <= sel_x;
        s1_ftz    <= i_ftz;
      end
    end
  end

  logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic invalid, div_zero, any_inf;
  logic r_exp_ones, r_exp_zero, r_man_nz;

  assign {a_nan, a_inf, a_zero} = s1_cls_a;
  assign {b_nan, b_inf, b_zero} = s1_cls_b;

  assign invalid = a_nan || b_nan
                || (!s1_op[1] && a_inf && b_inf && (s1_sign_a ^ s1_sign_b ^ s1_op[0]))
                || (s1_op == OP_MUL && ((a_inf && b_zero) || (a_zero && b_inf)))
                || (s1_op == OP_DIV && ((a_zero && b_zero) || (a_inf && b_inf)));
  assign div_zero = (s1_op == OP_DIV) && !a_inf && !a_zero && b_zero;
  assign any_inf  = a_inf || b_inf;

  assign r_exp_ones = &s1_r[BIT_WIDTH-2 -: EXP_WIDTH];
  assign r_exp_zero = ~|s1_r[BIT_WIDTH-2 -: EXP_WIDTH];
  assign r_man_nz   = |s1_r[MAN_WIDTH-1:0];

  // Priority-ordered result override and flag generation.
  always_comb begin
    fin_out = s1_r;
    fin_exc = {4'b0000, s1_x};
    if (invalid) begin
      fin_out = QNAN;
      fin_exc = 5'b00010;
    end else if (div_zero) begin
      fin_out = inf_of(s1_sign_a ^ s1_sign_b);
      fin_exc = 5'b00100;
    end else if (any_inf) begin
      fin_exc = 5'b00000;
    end else if (r_exp_ones && s1_x) begin
      fin_out = inf_of(s1_r[BIT_WIDTH-1]);
      fin_exc = 5'b10001;
    end else if (r_exp_zero && s1_x) begin
      fin_out = s1_ftz ? zero_of(s1_r[BIT_WIDTH-1]) : s1_r;
      fin_exc = 5'b01001;
    end else if (s1_ftz && r_exp_zero && r_man_nz) begin
      fin_out = zero_of(s1_r[BIT_WIDTH-1]);
      fin_exc = 5'b01001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid     <= 1'b0;
      o_output    <= '0;
      o_exception <= '0;
    end else if (s2_load) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_output    <= fin_out;
        o_exception <= fin_exc;
      end
    end
  end

  // A clear coinciding with a handshake keeps only the new beat's flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_sticky <= '0;
    end else if (out_fire) begin
      o_sticky <= i_flag_clear ? o_exception : (o_sticky | o_exception);
    end else if (i_flag_clear) begin
      o_sticky <= '0;
    end
  end

endmodule

// File: tb/tb_fpu_exception_pipe.sv
// Bench for fpu_exception_pipe: directed vector table, stall/sticky/reset sequences,
// randomized traffic against a queue-based reference model, and a 64-bit smoke check.
module tb_fpu_exception_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, dut_ready, out_valid, cons_ready;
  logic [1:0]  op;
  logic [31:0] a, b, add_o, sub_o, mul_o, div_o, res;
  logic        add_x, sub_x, mul_x, div_x, ftz, clr;
  logic [4:0]  exc, sticky;

  logic        v64, rdy64, ovalid64;
  logic [63:0] a64, b64, res64;
  logic [4:0]  exc64, sticky64;

  always #5 clk = ~clk;

  fpu_exception_pipe #(.BIT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_valid(in_valid), .o_ready(dut_ready),
    .i_operation(op), .i_inputA(a), .i_inputB(b),
    .i_add_out(add_o), .i_sub_out(sub_o), .i_mul_out(mul_o), .i_div_out(div_o),
    .i_add_inexact(add_x), .i_sub_inexact(sub_x), .i_mul_inexact(mul_x),
    .i_div_inexact(div_x), .i_ftz(ftz), .i_flag_clear(clr),
    .o_valid(out_valid), .i_ready(cons_ready), .o_output(res),
    .o_exception(exc), .o_sticky(sticky)
  );

  fpu_exception_pipe #(.BIT_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .i_valid(v64), .o_ready(rdy64),
    .i_operation(2'b00), .i_inputA(a64), .i_inputB(b64),
    .i_add_out(64'h0123456789ABCDEF), .i_sub_out(64'h0), .i_mul_out(64'h0),
    .i_div_out(64'h0), .i_add_inexact(1'b0), .i_sub_inexact(1'b0),
    .i_mul_inexact(1'b0), .i_div_inexact(1'b0), .i_ftz(1'b0), .i_flag_clear(1'b0),
    .o_valid(ovalid64), .i_ready(1'b1), .o_output(res64),
    .o_exception(exc64), .o_sticky(sticky64)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, r;
    logic        x, ftz;
    logic [31:0] eo;
    logic [4:0]  ee;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    logic [4:0]  exc;
    int          acc;
  } sb_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          edges = 0;
  sb_t         q[$];
  logic [4:0]  m_sticky = '0;
  logic [31:0] cur_out;
  logic [4:0]  cur_exc;
  vec_t        tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: classification and priority rules written directly as arithmetic.
  function automatic logic [7:0]  exp_of(input logic [31:0] v); return v[30:23]; endfunction
  function automatic logic [22:0] man_of(input logic [31:0] v); return v[22:0];  endfunction
  function automatic bit is_nan(input logic [31:0] v);  return exp_of(v) == 8'd255 && man_of(v) != 0; endfunction
  function automatic bit is_inf(input logic [31:0] v);  return exp_of(v) == 8'd255 && man_of(v) == 0; endfunction
  function automatic bit is_zero(input logic [31:0] v); return exp_of(v) == 8'd0   && man_of(v) == 0; endfunction

  function automatic logic [36:0] model(input logic [1:0] o, input logic [31:0] va, vb, r,
                                        input logic x, f);
    logic sa, sb;
    sa = va[31];
    sb = vb[31];
    if (is_nan(va) || is_nan(vb)
        || (o <= 2'd1 && is_inf(va) && is_inf(vb) && (sa ^ sb ^ o[0]))
        || (o == 2'd2 && ((is_inf(va) && is_zero(vb)) || (is_zero(va) && is_inf(vb))))
        || (o == 2'd3 && ((is_zero(va) && is_zero(vb)) || (is_inf(va) && is_inf(vb)))))
      return {32'h7FC00000, 5'b00010};
    if (o == 2'd3 && !is_inf(va) && !is_zero(va) && is_zero(vb))
      return {sa ^ sb, 8'hFF, 23'h0, 5'b00100};
    if (is_inf(va) || is_inf(vb)) return {r, 5'b00000};
    if (exp_of(r) == 8'd255 && x) return {r[31], 8'hFF, 23'h0, 5'b10001};
    if (exp_of(r) == 8'd0 && x)   return {(f ? {r[31], 31'h0} : r), 5'b01001};
    if (f && exp_of(r) == 8'd0 && man_of(r) != 0) return {r[31], 31'h0, 5'b01001};
    return {r, 4'b0000, x};
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: v[30:0] = 31'h0;
      1: v[30:0] = {8'hFF, 23'h0};
      2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      3: begin v[30:23] = 8'h00; v[0] = 1'b1; end
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  // Non-selected units carry random junk so that mis-selection is visible.
  task automatic drive(input logic [1:0] o, input logic [31:0] va, vb, r, input logic x, f);
    op = o; a = va; b = vb; ftz = f;
    add_o = $urandom; sub_o = $urandom; mul_o = $urandom; div_o = $urandom;
    add_x = 1'($urandom); sub_x = 1'($urandom); mul_x = 1'($urandom); div_x = 1'($urandom);
    case (o)
      2'd0: begin add_o = r; add_x = x; end
      2'd1: begin sub_o = r; sub_x = x; end
      2'd2: begin mul_o = r; mul_x = x; end
      default: begin div_o = r; div_x = x; end
    endcase
  endtask

  task automatic drive_vec(input int i);
    drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].x, tbl[i].ftz);
    cur_out = tbl[i].eo;
    cur_exc = tbl[i].ee;
  endtask

  task automatic drive_rand();
    logic [1:0]  o;
    logic [31:0] va, vb, r;
    logic        x, f;
    logic [36:0] m;
    o = 2'($urandom); va = rand_val(); vb = rand_val(); r = rand_val();
    x = 1'($urandom); f = 1'($urandom);
    drive(o, va, vb, r, x, f);
    m = model(o, va, vb, r, x, f);
    cur_out = m[36:5];
    cur_exc = m[4:0];
  endtask

  // One clock: check handshake/occupancy model at negedge, update scoreboard at posedge.
  task automatic cycle(output bit acc);
    bit exp_vld, exp_rdy, ohs;
    @(negedge clk);
    exp_vld = (q.size() > 0) && (edges - q[0].acc >= 1);
    exp_rdy = (q.size() < 2) || cons_ready;
    check("o_ready", 64'(dut_ready), 64'(exp_rdy));
    check("o_valid", 64'(out_valid), 64'(exp_vld));
    if (exp_vld && out_valid === 1'b1) begin
      check("o_output", 64'(res), 64'(q[0].out));
      check("o_exception", 64'(exc), 64'(q[0].exc));
    end
    check("o_sticky", 64'(sticky), 64'(m_sticky));
    ohs = exp_vld && cons_ready;
    acc = in_valid && exp_rdy && !rst;
    @(posedge clk);
    edges++;
    if (rst) begin
      q.delete();
      m_sticky = '0;
    end else begin
      if (ohs) begin
        m_sticky = clr ? q[0].exc : (m_sticky | q[0].exc);
        void'(q.pop_front());
      end else if (clr) begin
        m_sticky = '0;
      end
      if (acc) q.push_back('{out: cur_out, exc: cur_exc, acc: edges});
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int k;
    bit pending;

    tbl[0]  = '{2'd0, 32'h7F800000, 32'hFF800000, 32'h12345678, 1'b0, 1'b0, 32'h7FC00000, 5'b00010};
    tbl[1]  = '{2'd3, 32'h3F800000, 32'h80000000, 32'h12345678, 1'b0, 1'b0, 32'hFF800000, 5'b00100};
    tbl[2]  = '{2'd3, 32'h00000000, 32'h00000000, 32'h12345678, 1'b1, 1'b0, 32'h7FC00000, 5'b00010};
    tbl[3]  = '{2'd2, 32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, 32'h7F800000, 5'b10001};
    tbl[4]  = '{2'd2, 32'h80800000, 32'h3F000000, 32'h80000001, 1'b1, 1'b1, 32'h80000000, 5'b01001};
    tbl[5]  = '{2'd2, 32'h80800000, 32'h3F000000, 32'h80000001, 1'b1, 1'b0, 32'h80000001, 5'b01001};
    tbl[6]  = '{2'd1, 32'h7F800000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 32'h7FC00000, 5'b00010};
    tbl[7]  = '{2'd0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0, 32'h7F800000, 5'b00000};
    tbl[8]  = '{2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1, 1'b0, 32'h40400000, 5'b00001};
    tbl[9]  = '{2'd2, 32'hFF800000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h7FC00000, 5'b00010};
    tbl[10] = '{2'd2, 32'h00800000, 32'h00800000, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 5'b01001};
    tbl[11] = '{2'd1, 32'h7FC00001, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 5'b00010};
    tbl[12] = '{2'd3, 32'h7F800000, 32'hFF800000, 32'h00000000, 1'b0, 1'b0, 32'h7FC00000, 5'b00010};
    tbl[13] = '{2'd3, 32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 32'h7F800000, 5'b00000};

    rst = 1'b1; in_valid = 1'b0; cons_ready = 1'b1; clr = 1'b0;
    drive(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cur_out = '0; cur_exc = '0;
    v64 = 1'b0; a64 = 64'h7FF0000000000000; b64 = 64'hFFF0000000000000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_output", 64'(res), 64'h0);
    check("reset_exception", 64'(exc), 64'h0);
    idle(1);
    rst = 1'b0;
    idle(1);

    // Directed vectors at full throughput.
    for (int i = 0; i < 14; i++) begin
      drive_vec(i);
      in_valid = 1'b1;
      cycle(acc);
      check("table_accept", 64'(acc), 64'h1);
    end
    idle(3);

    // Sticky: clear without handshake, accumulate invalid+overflow, clear with a handshake.
    clr = 1'b1; idle(1); clr = 1'b0;
    check("sticky_cleared", 64'(sticky), 64'h0);
    drive_vec(0); in_valid = 1'b1; cycle(acc);
    drive_vec(3); cycle(acc);
    idle(3);
    check("sticky_accum", 64'(sticky), 64'(5'b10011));
    drive_vec(8); in_valid = 1'b1; cycle(acc);
    idle(1);
    clr = 1'b1; idle(1); clr = 1'b0;
    check("sticky_clear_hs", 64'(sticky), 64'(5'b00001));
    idle(2);

    // Four back-to-back beats with the consumer stalled for three cycles.
    k = 0;
    for (int c = 0; c < 12; c++) begin
      cons_ready = (c >= 3);
      if (k < 4) begin drive_vec(k + 1); in_valid = 1'b1; end
      else in_valid = 1'b0;
      cycle(acc);
      if (c == 2) check("ready_drop_after_two", 64'(acc), 64'h0);
      if (acc) k++;
    end
    check("all_four_accepted", 64'(k), 64'd4);
    check("stall_drained", 64'(q.size()), 64'd0);

    // Reset with beats in flight.
    cons_ready = 1'b0;
    drive_vec(3); in_valid = 1'b1; cycle(acc);
    drive_vec(0); cycle(acc);
    in_valid = 1'b0; rst = 1'b1; cycle(acc); rst = 1'b0;
    check("midrst_valid", 64'(out_valid), 64'h0);
    check("midrst_sticky", 64'(sticky), 64'h0);
    cons_ready = 1'b1;
    idle(2);

    // Randomized traffic with random backpressure and occasional clears.
    pending = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!pending) begin
        if ($urandom_range(0, 3) != 0) begin drive_rand(); pending = 1'b1; end
      end
      in_valid   = pending;
      cons_ready = ($urandom_range(0, 9) < 7);
      clr        = ($urandom_range(0, 19) == 0);
      cycle(acc);
      if (acc) pending = 1'b0;
    end
    clr = 1'b0; cons_ready = 1'b1;
    idle(4);
    check("random_drained", 64'(q.size()), 64'd0);

    // 64-bit instance: Inf + -Inf gives the canonical double qNaN after two cycles.
    @(negedge clk);
    check("w64_ready", 64'(rdy64), 64'h1);
    v64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0;
    check("w64_valid_early", 64'(ovalid64), 64'h0);
    @(posedge clk); #1;
    check("w64_valid", 64'(ovalid64), 64'h1);
    check("w64_output", res64, 64'h7FF8000000000000);
    check("w64_exception", 64'(exc64), 64'(5'b00010));
    @(posedge clk); #1;
    check("w64_sticky", 64'(sticky64), 64'(5'b00010));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
